pipe_ctrl_hazard: RTL

PIPE_CTRL_HAZARD -- requirements
Module: pipe_ctrl_hazard

---
 rtl/pipe_ctrl_hazard.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_hazard.sv
// Control decode, D/E/M/W control pipeline and hazard unit for a 5-stage RISC-V core.
// Define PIPE_CTRL_FWD_EN to build E-stage forwarding; without it RAW hazards are resolved by stalling.
module pipe_ctrl_hazard #(
  parameter int         REG_AW      = 5,
  parameter logic [2:0] RESULT_LOAD = 3'b001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        opD,
  input  logic [2:0]        funct3D,
  input  logic              funct7b5D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              ZeroE,
  input  logic              OverflowE,
  input  logic              CarryE,
  input  logic              NegativeE,
  output logic [2:0]        ResultSrcW,
  output logic              MemWriteM,
  output logic              PCSrcE,
  output logic              ALUSrcE,
  output logic              RegWriteW,
  output logic              PCResultSrcE,
  output logic [2:0]        ImmSrcD,
  output logic [3:0]        ALUControlE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE
);

  typedef struct packed {
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic              regWrite;
    logic [2:0]        resultSrc;
    logic              memWrite;
    logic [3:0]        aluControl;
    logic              aluSrc;
    logic              pcResultSrc;
    logic [REG_AW-1:0] rd;
  } deCtlT;

  logic       regWriteD, memWriteD, aluSrcD, pcResultSrcD;
  logic [2:0] resultSrcD;
  logic [1:0] aluOpD;
  logic [3:0] aluControlD;
  deCtlT      deD, deE;

  logic              regWriteM;
  logic [2:0]        resultSrcM;
  logic [REG_AW-1:0] rdM;
  logic              lwStall;

  // Main decoder. ResultSrc: 000 ALU, RESULT_LOAD memory, 010 PC+4, 011 imm, 100 PC+imm.
  always_comb begin
    regWriteD    = 1'b0;
    memWriteD    = 1'b0;
    aluSrcD      = 1'b0;
    pcResultSrcD = 1'b0;
    resultSrcD   = 3'b000;
    ImmSrcD      = 3'b000;
    aluOpD       = 2'b00;
    case (opD)
      7'b0000011: begin regWriteD = 1'b1; aluSrcD = 1'b1; resultSrcD = RESULT_LOAD; end
      7'b0100011: begin memWriteD = 1'b1; aluSrcD = 1'b1; ImmSrcD = 3'b001; end
      7'b0110011: begin regWriteD = 1'b1; aluOpD = 2'b10; end
      7'b0010011: begin regWriteD = 1'b1; aluSrcD = 1'b1; aluOpD = 2'b10; end
      7'b1100011: begin ImmSrcD = 3'b010; aluOpD = 2'b01; end
      7'b1101111: begin regWriteD = 1'b1; ImmSrcD = 3'b011; resultSrcD = 3'b010; end
      7'b1100111: begin
        regWriteD    = 1'b1;
        aluSrcD      = 1'b1;
        resultSrcD   = 3'b010;
        pcResultSrcD = 1'b1;
      end
      7'b0110111: begin regWriteD = 1'b1; ImmSrcD = 3'b100; resultSrcD = 3'b011; end
      7'b0010111: begin regWriteD = 1'b1; ImmSrcD = 3'b100; resultSrcD = 3'b100; end
      default: ;
    endcase
  end

  // ALU decoder. funct7b5 selects SUB only for R-type; in I-type it is an immediate bit.
  always_comb begin
    aluControlD = 4'b0000;
    case (aluOpD)
      2'b01: aluControlD = 4'b0001;
      2'b10: begin
        case (funct3D)
          3'b000:  aluControlD = (funct7b5D && opD[5]) ? 4'b0001 : 4'b0000;
          3'b001:  aluControlD = 4'b0111;
          3'b010:  aluControlD = 4'b0101;
          3'b011:  aluControlD = 4'b0110;
          3'b100:  aluControlD = 4'b0100;
          3'b101:  aluControlD = funct7b5D ? 4'b1001 : 4'b1000;
          3'b110:  aluControlD = 4'b0011;
          default: aluControlD = 4'b0010;
        endcase
      end
      default: aluControlD = 4'b0000;
    endcase
  end

  assign deD = {opD, funct3D, regWriteD, resultSrcD, memWriteD, aluControlD,
                aluSrcD, pcResultSrcD, RdD};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       deE <= '0;
    else if (FlushE) deE <= '0;
    else             deE <= deD;
  end

  assign ALUControlE  = deE.aluControl;
  assign ALUSrcE      = deE.aluSrc;
  assign PCResultSrcE = deE.pcResultSrc;

  // Branch decoder. CarryE is the no-borrow flag of rs1-rs2, so unsigned less-than is !CarryE.
  always_comb begin
    PCSrcE = 1'b0;
    case (deE.op)
      7'b1100011: begin
        case (deE.funct3)
          3'b000:  PCSrcE = ZeroE;
          3'b001:  PCSrcE = ~ZeroE;
          3'b100:  PCSrcE = NegativeE ^ OverflowE;
          3'b101:  PCSrcE = ~(NegativeE ^ OverflowE);
          3'b110:  PCSrcE = ~CarryE;
          3'b111:  PCSrcE = CarryE;
          default: PCSrcE = 1'b0;
        endcase
      end
      7'b1101111, 7'b1100111: PCSrcE = 1'b1;
      default: PCSrcE = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWriteM  <= 1'b0;
      resultSrcM <= 3'b000;
      MemWriteM  <= 1'b0;
      rdM        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 3'b000;
    end else begin
      regWriteM  <= deE.regWrite;
      resultSrcM <= deE.resultSrc;
      MemWriteM  <= deE.memWrite;
      rdM        <= deE.rd;
      RegWriteW  <= regWriteM;
      ResultSrcW <= resultSrcM;
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  logic [REG_AW-1:0] rs1E, rs2E, rdW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1E <= '0;
      rs2E <= '0;
    end else if (FlushE) begin
      rs1E <= '0;
      rs2E <= '0;
    end else begin
      rs1E <= Rs1D;
      rs2E <= Rs2D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdW <= '0;
    else       rdW <= rdM;
  end

  // M is the younger producer, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (regWriteM && (rdM != '0) && (rdM == rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (rdW != '0) && (rdW == rs1E)) ForwardAE = 2'b01;
    if (regWriteM && (rdM != '0) && (rdM == rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (rdW != '0) && (rdW == rs2E)) ForwardBE = 2'b01;
  end

  assign lwStall = (deE.resultSrc == RESULT_LOAD) && (deE.rd != '0) &&
                   ((deE.rd == Rs1D) || (deE.rd == Rs2D));
`else
  assign ForwardAE = 2'b00;
  assign ForwardBE = 2'b00;

  // No bypass: hold D until the producer has reached W (write-first register file).
  assign lwStall = ((Rs1D != '0) && ((deE.regWrite && (Rs1D == deE.rd)) ||
                                     (regWriteM && (Rs1D == rdM)))) ||
                   ((Rs2D != '0) && ((deE.regWrite && (Rs2D == deE.rd)) ||
                                     (regWriteM && (Rs2D == rdM))));
`endif

  assign StallF = lwStall;
  assign StallD = lwStall;
  assign FlushD = PCSrcE;
  assign FlushE = lwStall | PCSrcE;

endmodule
